// File: rtl/msx_audio_pkg.sv
// rtl/msx_audio_pkg.sv - shared types and helpers for the msx audio DAC
package msx_audio_pkg;

  typedef enum logic {
    RAMP = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Extra integrator headroom bits for the second-order modulator
  localparam int GUARD_W = 4;

  function automatic int mid_of(input int w);
    return 1 << (w - 1);
  endfunction

  function automatic int qtr_of(input int w);
    return 1 << (w - 2);
  endfunction

endpackage

// File: rtl/msx_dsm_mod.sv
// rtl/msx_dsm_mod.sv - per-channel 1-bit modulator; AUDIO_DSM2_EN selects second order
module msx_dsm_mod
  import msx_audio_pkg::*;
#(
  parameter int IN_W = 14
) (
  input  logic            clk_sys,
  input  logic            reset,
  input  logic [IN_W-1:0] tgt,
  output logic            out
);

`ifdef AUDIO_DSM2_EN
  localparam int IW = IN_W + GUARD_W;
  localparam logic signed [IW-1:0] FB_ONE = IW'(1) << IN_W;
  localparam logic signed [IW+1:0] HI = {3'b000, {(IW-1){1'b1}}};
  localparam logic signed [IW+1:0] LO = {3'b111, {(IW-1){1'b0}}};

  logic signed [IW-1:0] i1_q, i1_d, i2_q, i2_d, fb, tgt_s;
  logic signed [IW+1:0] sum1, sum2;
  logic                 out_q, out_d;

  function automatic logic signed [IW+1:0] sx(input logic signed [IW-1:0] a);
    return {{2{a[IW-1]}}, a};
  endfunction

  // Integrators saturate instead of wrapping so a transient cannot flip the sign
  function automatic logic signed [IW-1:0] clamp(input logic signed [IW+1:0] v);
    if (v > HI) return HI[IW-1:0];
    if (v < LO) return LO[IW-1:0];
    return v[IW-1:0];
  endfunction

  assign tgt_s = {{GUARD_W{1'b0}}, tgt};
  assign fb    = out_q ? FB_ONE : '0;

  always_comb begin
    sum1  = sx(i1_q) + sx(tgt_s) - sx(fb);
    i1_d  = clamp(sum1);
    sum2  = sx(i2_q) + sx(i1_d) - sx(fb);
    i2_d  = clamp(sum2);
    out_d = ~i2_d[IW-1];
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      i1_q  <= '0;
      i2_q  <= '0;
      out_q <= 1'b0;
    end else begin
      i1_q  <= i1_d;
      i2_q  <= i2_d;
      out_q <= out_d;
    end
  end

  assign out = out_q;
`else
  logic [IN_W-1:0] acc_q, acc_d;
  logic            c_q, c_d;

  always_comb begin
    {c_d, acc_d} = {1'b0, acc_q} + {1'b0, tgt};
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      acc_q <= '0;
      c_q   <= 1'b0;
    end else begin
      acc_q <= acc_d;
      c_q   <= c_d;
    end
  end

  assign out = c_q;
`endif

endmodule

// File: rtl/msx_audio_dac.sv
// rtl/msx_audio_dac.sv - sample divider, tape sync, source mux and soft-start FSM
// feeding two msx_dsm_mod channels (AUDIO_DSM2_EN picks the modulator order)
module msx_audio_dac
  import msx_audio_pkg::*;
#(
  parameter int IN_W       = 14,
  parameter int SAMPLE_DIV = 486,
  parameter int RAMP_SHIFT = 0
) (
  input  logic            clk_sys,
  input  logic            reset,
  input  logic [IN_W-1:0] pcm_in,
  input  logic            cmt_in,
  input  logic            tape_en,
  output logic            audio_l,
  output logic            audio_r,
  output logic            sample_stb,
  output logic            ramp_done
);

  localparam int DIV_W = $clog2(SAMPLE_DIV);
  localparam logic [IN_W-1:0] MID  = IN_W'(mid_of(IN_W));
  localparam logic [IN_W-1:0] QTR  = IN_W'(qtr_of(IN_W));
  localparam logic [IN_W:0]   STEP = (IN_W + 1)'(1) << RAMP_SHIFT;

  logic [DIV_W-1:0] div_q, div_d;
  logic             cmt_s1_q, cmt_s2_q;
  logic [IN_W-1:0]  ramp_q, ramp_d;
  logic [IN_W-1:0]  tgt_l_q, tgt_l_d, tgt_r_q, tgt_r_d;
  logic             stb_q, stb_d, done_q, done_d;
  state_t           state_q, state_d;

  logic             strobe;
  logic [IN_W-1:0]  pcm_u, src_r;
  logic [IN_W:0]    ramp_sum;

  assign strobe   = (div_q == DIV_W'(SAMPLE_DIV - 1));
  assign pcm_u    = {~pcm_in[IN_W-1], pcm_in[IN_W-2:0]};
  assign src_r    = tape_en ? (cmt_s2_q ? MID + QTR : MID - QTR) : pcm_u;
  assign ramp_sum = {1'b0, ramp_q} + STEP;

  always_comb begin
    div_d   = strobe ? '0 : div_q + DIV_W'(1);
    stb_d   = strobe;
    state_d = state_q;
    ramp_d  = ramp_q;
    tgt_l_d = tgt_l_q;
    tgt_r_d = tgt_r_q;
    done_d  = done_q;
    if (strobe) begin
      case (state_q)
        RAMP: begin
          // Only hand over once midscale has been held for a full sample period
          if (ramp_q == MID) begin
            state_d = RUN;
            done_d  = 1'b1;
            tgt_l_d = pcm_u;
            tgt_r_d = src_r;
          end else begin
            ramp_d  = (ramp_sum >= {1'b0, MID}) ? MID : ramp_sum[IN_W-1:0];
            tgt_l_d = ramp_d;
            tgt_r_d = ramp_d;
          end
        end
        RUN: begin
          tgt_l_d = pcm_u;
          tgt_r_d = src_r;
        end
        default: state_d = RAMP;
      endcase
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      div_q    <= '0;
      cmt_s1_q <= 1'b0;
      cmt_s2_q <= 1'b0;
      ramp_q   <= '0;
      tgt_l_q  <= '0;
      tgt_r_q  <= '0;
      stb_q    <= 1'b0;
      done_q   <= 1'b0;
      state_q  <= RAMP;
    end else begin
      div_q    <= div_d;
      cmt_s1_q <= cmt_in;
      cmt_s2_q <= cmt_s1_q;
      ramp_q   <= ramp_d;
      tgt_l_q  <= tgt_l_d;
      tgt_r_q  <= tgt_r_d;
      stb_q    <= stb_d;
      done_q   <= done_d;
      state_q  <= state_d;
    end
  end

  assign sample_stb = stb_q;
  assign ramp_done  = done_q;

  msx_dsm_mod #(.IN_W(IN_W)) u_dsm_l (
    .clk_sys (clk_sys),
    .reset   (reset),
    .tgt     (tgt_l_q),
    .out     (audio_l)
  );

  msx_dsm_mod #(.IN_W(IN_W)) u_dsm_r (
    .clk_sys (clk_sys),
    .reset   (reset),
    .tgt     (tgt_r_q),
    .out     (audio_r)
  );

endmodule
